// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the CPU load/store interface.
// One request at a time, fixed LATENCY edges to the response, response held
// until the requester takes it.
// Optional build macro: DMEM_ALIGN_CHECK_EN (flag misaligned requests with
// resp_err and suppress their array access).
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request latched, latency counter running
// RESP  | response presented, waiting for resp_ready
module dmem_responder #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 3;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              misal_q;
  logic              access;
  logic              accept;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    access     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = reset;
        if (req_valid && reset) state_next = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency countdown and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 4'd0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        idx_q   <= req_addr[ADDR_W-1:3];
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        resp_err   <= misal_q;
        resp_rdata <= (wr_q || misal_q) ? '0 : mem[idx_q];
      end else if (resp_valid && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Store commit on the edge entering RESP; array has no reset.
  always_ff @(posedge clk) begin
    if (access && wr_q && !misal_q) mem[idx_q] <= wdata_q;
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Misalignment flag captured with the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      misal_q <= 1'b0;
    else if (accept) misal_q <= (req_addr[2:0] != 3'd0);
  end
`else
  // Byte offset is dropped: the address is truncated to a word index.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[2:0];
  assign misal_q = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the load/store interface driven by the pipelined CPU's memory stage.
- Accepts one read or write request at a time over a valid/ready handshake.
- Models a fixed multi-cycle access latency, then returns a response over a second valid/ready handshake.
- Replaces the single-cycle data memory so the pipeline's stall and forward logic can be exercised against a realistic responder.

Parameters:
- DATA_W, 64: word width in bits.
- ADDR_W, 10: byte-address width. Array depth is 2^(ADDR_W-3) 64-bit words.
- LATENCY, 2: edges from request acceptance to resp_valid rising. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester consumes the response.
- resp_rdata  out  DATA_W  load data; 0 for stores and errors.
- resp_err  out  1  request was rejected (misaligned address).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, WAIT, RESP. A 4-bit down-counter cnt tracks latency.
- Reset (reset low, asynchronous):
  - state=IDLE, cnt=0.
  - resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - req_ready=0 while reset is low.
  - Array contents are not reset.
- IDLE:
  - req_ready=1.
  - Accept at edge T when req_valid && req_ready: latch write, addr, wdata; cnt<=LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0.
  - Each edge: if cnt==0, perform the access and go to RESP; else cnt<=cnt-1.
  - Result: resp_valid rises after edge T+LATENCY exactly. LATENCY=1 spends one cycle in WAIT.
- Access, on the edge entering RESP:
  - Load: resp_rdata <= mem[addr[ADDR_W-1:3]].
  - Store: mem[addr[ADDR_W-1:3]] <= wdata; resp_rdata <= 0.
  - resp_err is set per the Optional Feature.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until the handshake.
  - req_ready=0; requests are not overlapped with a pending response.
  - On resp_valid && resp_ready at an edge: go to IDLE; resp_valid, resp_rdata, resp_err cleared to 0 on that edge.
  - A new request is acceptable only from the following cycle.
- Backpressure: resp_ready may stay low indefinitely; the responder holds in RESP and neither loses nor changes the response.
- req_valid in WAIT/RESP is ignored and not queued. The requester must hold it until req_ready.
- Load after store to the same address returns the new data; the store commits before the load can be accepted.
- Reset mid-operation:
  - A store not yet committed (still in WAIT) is dropped and the array is unchanged.
  - A store already committed remains.
  - The response is discarded.
- Address wrap: bits above ADDR_W do not exist. The top word (all-ones index) is valid.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - A request with req_addr[2:0]!=0 sets resp_err=1 in RESP and returns resp_rdata=0.
  - A misaligned store does not modify the array.
  - Latency and handshake are unchanged.
- Undefined:
  - req_addr[2:0] is ignored (address truncated to a word index).
  - resp_err is tied to 0.

Test Plan:
- Reset then idle, LATENCY=2 → req_ready=1, resp_valid=0, busy=0. Drive reset low mid-WAIT → state IDLE, resp_valid=0 immediately.
- Store 0x0123456789ABCDEF to addr 0x008, resp_ready=1 → resp_valid high exactly 2 edges after acceptance, resp_rdata=0, resp_err=0. Then load 0x008 → resp_rdata=0x0123456789ABCDEF.
- Load with resp_ready held low for 10 cycles → resp_valid and resp_rdata stable throughout, req_ready=0; req_valid pulses in that window are ignored. Releasing resp_ready → IDLE the next edge.
- Store 0xAA to addr 0x3F8 (top word), ADDR_W=10 → load 0x3F8 returns 0xAA and load 0x000 is unaffected. Repeat with LATENCY=1 → response after 1 edge.
- Store 0x55 to 0x010, then reset asserted while in WAIT; after release, load 0x010 → returns the pre-store contents, not 0x55.
- With DMEM_ALIGN_CHECK_EN: store to 0x00C → resp_err=1, array unchanged. Without the macro: the same store writes word index 1 and resp_err=0.
